// File: rtl/peasant_signed_mult_if.sv
// peasant_signed_mult_if -- operand/result handshake bundle for peasant_signed_mult.
//   master : producer/consumer side (drives A, B, iSigned, iValid, oReady)
//   slave  : multiplier side (drives iReady, result, oValid[, oCycles])
// Optional: PEASANT_CYCLES_EN adds oCycles (RUN iterations of the last product).
interface peasant_signed_mult_if #(
  parameter int NA = 8,
  parameter int NB = 8
);
  localparam int CW = $clog2(NB + 1);

  logic [NA-1:0]    A;
  logic [NB-1:0]    B;
  logic             iSigned;
  logic             iValid;
  logic             iReady;
  logic [NA+NB-1:0] result;
  logic             oValid;
  logic             oReady;
`ifdef PEASANT_CYCLES_EN
  logic [CW-1:0]    oCycles;
`endif

  modport master (
    output A, B, iSigned, iValid, oReady,
`ifdef PEASANT_CYCLES_EN
    input  oCycles,
`endif
    input  iReady, result, oValid
  );

  modport slave (
    input  A, B, iSigned, iValid, oReady,
`ifdef PEASANT_CYCLES_EN
    output oCycles,
`endif
    output iReady, result, oValid
  );
endinterface

// File: rtl/peasant_signed_mult.sv
// peasant_signed_mult -- sequential shift-add multiplier, NA x NB -> NA+NB bits,
// per-transaction signed/unsigned, early exit once the remaining multiplier
// bits are zero. One transaction in flight.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : peasant_signed_mult_if.slave (A, B, iSigned, iValid/iReady,
//           result, oValid/oReady, oCycles when enabled)
// Optional: PEASANT_CYCLES_EN exposes oCycles, the RUN iteration count of the
// product currently presented in DONE.
// The interface instance must carry the same NA/NB as this module.
module peasant_signed_mult #(
  parameter int NA = 8,
  parameter int NB = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  peasant_signed_mult_if.slave  bus
);
  localparam int W  = NA + NB;
`ifdef PEASANT_CYCLES_EN
  localparam int CW = $clog2(NB + 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [NB-1:0] mult_q, mult_d;
  logic          sign_q, sign_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovalid_q, ovalid_d;
`ifdef PEASANT_CYCLES_EN
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ocycles_q, ocycles_d;
`endif

  logic          ready;
  logic          accept;
  logic [NA-1:0] a_mag;
  logic [NB-1:0] b_mag;
  logic [W-1:0]  acc_nxt;
  logic [NB-1:0] mult_nxt;

  // Magnitudes; the most negative value maps onto its unsigned bit pattern
  // (e.g. 8'h80 -> 128), so no extra bit is needed.
  always_comb begin
    a_mag = (bus.iSigned && bus.A[NA-1]) ? (~bus.A) + NA'(1) : bus.A;
    b_mag = (bus.iSigned && bus.B[NB-1]) ? (~bus.B) + NB'(1) : bus.B;
  end

  assign accept   = bus.iValid && ready;
  assign acc_nxt  = mult_q[0] ? acc_q + mcand_q : acc_q;
  assign mult_nxt = mult_q >> 1;

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      ovalid_q  <= 1'b0;
`ifdef PEASANT_CYCLES_EN
      count_q   <= '0;
      ocycles_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      sign_q    <= sign_d;
      result_q  <= result_d;
      ovalid_q  <= ovalid_d;
`ifdef PEASANT_CYCLES_EN
      count_q   <= count_d;
      ocycles_q <= ocycles_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (b_mag == '0) ? DONE : RUN;
      RUN:  if (mult_nxt == '0) state_d = DONE;
      DONE: if (bus.oReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    sign_d    = sign_q;
    result_d  = result_q;
    ovalid_d  = ovalid_q;
`ifdef PEASANT_CYCLES_EN
    count_d   = count_q;
    ocycles_d = ocycles_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d  = bus.iSigned & (bus.A[NA-1] ^ bus.B[NB-1]);
          mcand_d = {{NB{1'b0}}, a_mag};
          mult_d  = b_mag;
          acc_d   = '0;
`ifdef PEASANT_CYCLES_EN
          count_d = '0;
`endif
          // Zero multiplier skips RUN entirely.
          if (b_mag == '0) begin
            result_d  = '0;
            ovalid_d  = 1'b1;
`ifdef PEASANT_CYCLES_EN
            ocycles_d = '0;
`endif
          end
        end
      end
      RUN: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        mult_d  = mult_nxt;
`ifdef PEASANT_CYCLES_EN
        count_d = count_q + CW'(1);
`endif
        // Last useful bit consumed: publish the signed product now.
        if (mult_nxt == '0) begin
          result_d  = sign_q ? -acc_nxt : acc_nxt;
          ovalid_d  = 1'b1;
`ifdef PEASANT_CYCLES_EN
          ocycles_d = count_q + CW'(1);
`endif
        end
      end
      DONE: if (bus.oReady) ovalid_d = 1'b0;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready       = (state_q == IDLE) && reset;
    bus.iReady  = ready;
    bus.oValid  = ovalid_q;
    bus.result  = result_q;
`ifdef PEASANT_CYCLES_EN
    bus.oCycles = ocycles_q;
`endif
  end
endmodule
